request_pipe_stage: RTL and testbench

//  Downstream consumer of one producer request channel (address/id/valid + flush/flush_id).

---
 rtl/request_pipe_stage_pkg.sv | 24 ++
 rtl/req_pipe_slot.sv | 50 +++++
 rtl/request_pipe_stage.sv | 94 +++++++++
 tb/tb_request_pipe_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/request_pipe_stage_pkg.sv
// Shared widths, depth default and saturating counter helper for request_pipe_stage.
// Supplies ADDRESS_WIDTH / ID_WIDTH fallbacks when defines.vh has not set them.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

package request_pipe_stage_pkg;
    localparam int ADDR_W_DEFAULT     = `ADDRESS_WIDTH;
    localparam int ID_W_DEFAULT       = `ID_WIDTH;
    localparam int PIPE_DEPTH_DEFAULT = 4;
    localparam int SLOT_W             = 1 + ADDR_W_DEFAULT + ID_W_DEFAULT;
    localparam int CNT_W              = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // Saturating add of a small per-cycle increment (at most 8 per cycle).
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
        return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
    endfunction
endpackage

// File: rtl/req_pipe_slot.sv
// One pipeline slot: loads from upstream, empties when its beat moves on,
// and drops its post-move contents when a flush matches the id.
module req_pipe_slot
    import request_pipe_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int ID_W   = ID_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              move_out,
    input  logic              flush,
    input  logic [ID_W-1:0]   flush_id,
    input  logic [ADDR_W-1:0] src_address,
    input  logic [ID_W-1:0]   src_id,
    output logic              valid,
    output logic [ADDR_W-1:0] address,
    output logic [ID_W-1:0]   id,
    output logic              kill
);
    logic            nxt_valid;
    logic [ID_W-1:0] nxt_id;

    always_comb begin
        nxt_valid = valid;
        nxt_id    = id;
        if (load) begin
            nxt_valid = 1'b1;
            nxt_id    = src_id;
        end else if (move_out) begin
            nxt_valid = 1'b0;
        end
        kill = flush & nxt_valid & (nxt_id == flush_id);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            address <= '0;
            id      <= '0;
        end else begin
            valid <= nxt_valid & ~kill;
            if (load) begin
                address <= src_address;
                id      <= src_id;
            end
        end
    end
endmodule

// File: rtl/request_pipe_stage.sv
// In-order elastic request pipeline with id-matched flush and saturating retire count.
// Optional REQ_PIPE_FLUSH_CNT_EN adds a saturating flush_count output.
module request_pipe_stage
    import request_pipe_stage_pkg::*;
#(
    parameter int DEPTH  = PIPE_DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int ID_W   = ID_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_address,
    input  logic [ID_W-1:0]   in_id,
    input  logic              in_valid,
    output logic              out_stall,
    input  logic              flush,
    input  logic [ID_W-1:0]   flush_id,
    output logic [ADDR_W-1:0] ret_address,
    output logic [ID_W-1:0]   ret_id,
    output logic              ret_valid,
    input  logic              ret_ready,
`ifdef REQ_PIPE_FLUSH_CNT_EN
    output logic [CNT_W-1:0]  flush_count,
`endif
    output logic [CNT_W-1:0]  retire_count
);
    logic [DEPTH-1:0]             valid;
    logic [DEPTH-1:0]             move;
    logic [DEPTH-1:0]             kill;
    logic [DEPTH-1:0][ADDR_W-1:0] address;
    logic [DEPTH-1:0][ID_W-1:0]   id;
    logic                         accept;

    // Walk from the head back so each slot sees whether its successor frees up.
    always_comb begin
        move = '0;
        move[DEPTH-1] = valid[DEPTH-1] & ret_ready;
        for (int k = DEPTH-2; k >= 0; k--)
            move[k] = valid[k] & (~valid[k+1] | move[k+1]);
    end

    assign out_stall = valid[0] & ~move[0];
    assign accept    = in_valid & ~out_stall;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic              load;
        logic [ADDR_W-1:0] src_address;
        logic [ID_W-1:0]   src_id;
        if (k == 0) begin : g_entry
            assign load        = accept;
            assign src_address = in_address;
            assign src_id      = in_id;
        end else begin : g_body
            assign load        = move[k-1];
            assign src_address = address[k-1];
            assign src_id      = id[k-1];
        end
        req_pipe_slot #(.ADDR_W(ADDR_W), .ID_W(ID_W)) u_slot (
            .clk(clk), .reset(reset), .load(load), .move_out(move[k]),
            .flush(flush), .flush_id(flush_id),
            .src_address(src_address), .src_id(src_id),
            .valid(valid[k]), .address(address[k]), .id(id[k]), .kill(kill[k])
        );
    end

    assign ret_valid   = valid[DEPTH-1];
    assign ret_address = address[DEPTH-1];
    assign ret_id      = id[DEPTH-1];

    always_ff @(posedge clk) begin
        if (reset)
            retire_count <= '0;
        else if (ret_valid && ret_ready)
            retire_count <= sat_add(retire_count, 4'd1);
    end

`ifdef REQ_PIPE_FLUSH_CNT_EN
    logic [3:0] kill_cnt;

    // Slot 0 kill also covers an incoming beat discarded on the flush edge.
    always_comb begin
        kill_cnt = '0;
        for (int k = 0; k < DEPTH; k++)
            kill_cnt = kill_cnt + {3'b000, kill[k]};
    end

    always_ff @(posedge clk) begin
        if (reset)
            flush_count <= '0;
        else
            flush_count <= sat_add(flush_count, kill_cnt);
    end
`endif
endmodule

// File: tb/tb_request_pipe_stage.sv
// Directed self-checking bench for request_pipe_stage (DEPTH=4, 32-bit address, 8-bit id).
module tb_request_pipe_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_address;
    logic [7:0]  in_id;
    logic        in_valid;
    logic        out_stall;
    logic        flush;
    logic [7:0]  flush_id;
    logic [31:0] ret_address;
    logic [7:0]  ret_id;
    logic        ret_valid;
    logic        ret_ready;
    logic [15:0] retire_count;
`ifdef REQ_PIPE_FLUSH_CNT_EN
    logic [15:0] flush_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] got[$];

    request_pipe_stage #(.DEPTH(4), .ADDR_W(32), .ID_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_address(in_address), .in_id(in_id), .in_valid(in_valid),
        .out_stall(out_stall), .flush(flush), .flush_id(flush_id),
        .ret_address(ret_address), .ret_id(ret_id), .ret_valid(ret_valid),
        .ret_ready(ret_ready),
`ifdef REQ_PIPE_FLUSH_CNT_EN
        .flush_count(flush_count),
`endif
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] i);
        in_id      = i;
        in_address = 32'hA000_0000 + {24'h0, i};
        in_valid   = 1'b1;
    endtask

    // Collects every retiring id over a fixed window with ret_ready held high.
    task automatic drain(input int cycles);
        got.delete();
        ret_ready = 1'b1;
        repeat (cycles) begin
            if (ret_valid) got.push_back(ret_id);
            tick();
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; in_id = '0; in_address = '0;
        flush = 1'b0; flush_id = '0; ret_ready = 1'b0;
        tick(); tick();
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_ret_id", ret_id, 0);
        chk("rst_ret_addr", ret_address, 0);
        chk("rst_count", retire_count, 0);
        chk("rst_stall", out_stall, 0);
`ifdef REQ_PIPE_FLUSH_CNT_EN
        chk("rst_flush_count", flush_count, 0);
`endif
        reset = 1'b0;

        // 1: latency and in-order streaming
        ret_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(8'h11 + 8'(i));
            chk("t1_stall", out_stall, 0);
            tick();
        end
        in_valid = 1'b0;
        chk("t1_first_valid", ret_valid, 1);
        chk("t1_first_id", ret_id, 8'h11);
        chk("t1_first_addr", ret_address, 32'hA000_0011);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t1_order", ret_id, 8'h11 + 8'(i));
        end
        tick();
        chk("t1_empty", ret_valid, 0);
        chk("t1_count", retire_count, 4);

        // 2: backpressure fills the pipe, release drops stall combinationally
        ret_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'h11 + 8'(i));
            chk("t2_no_stall", out_stall, 0);
            tick();
        end
        send(8'h15);
        chk("t2_stall_up", out_stall, 1);
        ret_ready = 1'b1;
        #1;
        chk("t2_stall_drop", out_stall, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", ret_valid, 1);
            chk("t2_id", ret_id, 8'h11 + 8'(i));
            tick();
            in_valid = 1'b0;
        end
        chk("t2_empty", ret_valid, 0);
        chk("t2_count", retire_count, 9);

        // 3: flush kills one matching slot mid-pipe
        ret_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'h17 + 8'(i));
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b1; flush_id = 8'h19;
        tick();
        flush = 1'b0;
        drain(10);
        chk("t3_n", got.size(), 3);
        if (got.size() == 3) begin
            chk("t3_id0", got[0], 8'h17);
            chk("t3_id1", got[1], 8'h18);
            chk("t3_id2", got[2], 8'h1A);
        end
        chk("t3_count", retire_count, 12);
`ifdef REQ_PIPE_FLUSH_CNT_EN
        chk("t3_flush_count", flush_count, 1);
`endif

        // 4: flush of slot 0 in a stalled full pipe does not lower stall that cycle
        ret_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'h21 + 8'(i));
            tick();
        end
        send(8'h25);
        flush = 1'b1; flush_id = 8'h24;
        #1;
        chk("t4_stall_hold", out_stall, 1);
        tick();
        flush = 1'b0;
        chk("t4_stall_fall", out_stall, 0);
        in_valid = 1'b0;
        drain(10);
        chk("t4_n", got.size(), 3);
        if (got.size() == 3) begin
            chk("t4_id0", got[0], 8'h21);
            chk("t4_id1", got[1], 8'h22);
            chk("t4_id2", got[2], 8'h23);
        end
        chk("t4_count", retire_count, 15);
`ifdef REQ_PIPE_FLUSH_CNT_EN
        chk("t4_flush_count", flush_count, 2);
`endif

        // 5a: incoming beat matching the flush id is discarded
        ret_ready = 1'b1;
        send(8'h19);
        flush = 1'b1; flush_id = 8'h19;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        drain(8);
        chk("t5a_n", got.size(), 0);
        chk("t5a_count", retire_count, 15);
`ifdef REQ_PIPE_FLUSH_CNT_EN
        chk("t5a_flush_count", flush_count, 3);
`endif

        // 5b: head handshaking on the flush edge retires normally
        ret_ready = 1'b0;
        send(8'h19);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("t5b_head_valid", ret_valid, 1);
        chk("t5b_head_id", ret_id, 8'h19);
        ret_ready = 1'b1;
        flush = 1'b1; flush_id = 8'h19;
        tick();
        flush = 1'b0;
        chk("t5b_gone", ret_valid, 0);
        chk("t5b_count", retire_count, 16);
`ifdef REQ_PIPE_FLUSH_CNT_EN
        chk("t5b_flush_count", flush_count, 3);
`endif

        // 6: reset with requests in flight drops them
        ret_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(8'h41 + 8'(i));
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("t6_ret_valid", ret_valid, 0);
        chk("t6_count", retire_count, 0);
        chk("t6_stall", out_stall, 0);
        reset = 1'b0;
        drain(8);
        chk("t6_no_ghost", got.size(), 0);

        // 6: saturation of retire_count at 16'hFFFF
        ret_ready = 1'b1;
        n = 0;
        send(8'h55);
        while (retire_count !== 16'hFFFF && n < 70000) begin
            tick();
            n++;
        end
        chk("t6_reach_max", retire_count, 16'hFFFF);
        chk("t6_beat_present", ret_valid, 1);
        tick();
        chk("t6_saturated", retire_count, 16'hFFFF);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
